pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the enable and synchronous-clear inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use stalls, taken-branch squashes, data-memory wait states, multi-cycle MULT/DIV occupancy and exception flushes. Its state updates on the same falling clock edge as the pipeline registers it controls.

---
 rtl/pipe_hazard_ctrl_if.sv | 45 ++++
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller.
// The pipeline drives the master side; the controller uses the slave side.
interface pipe_hazard_ctrl_if #(
   parameter int REGW = 5
);
   logic [REGW-1:0] id_rs;
   logic [REGW-1:0] id_rt;
   logic            id_mdu_use;
   logic            id_branch_taken;
   logic            ex_memread;
   logic [REGW-1:0] ex_rt;
   logic            ex_mdu_start;
   logic            dmem_req;
   logic            dmem_ready;
   logic            exc_req;
   logic            pc_en;
   logic            ifid_en;
   logic            idex_en;
   logic            exmem_en;
   logic            memwb_en;
   logic            ifid_clr;
   logic            idex_clr;
   logic            exmem_clr;
   logic            memwb_clr;
   logic            mdu_busy;
   logic            state_o;

   modport master (
      output id_rs, id_rt, id_mdu_use, id_branch_taken,
             ex_memread, ex_rt, ex_mdu_start,
             dmem_req, dmem_ready, exc_req,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_clr, idex_clr, exmem_clr, memwb_clr,
             mdu_busy, state_o
   );

   modport slave (
      input  id_rs, id_rt, id_mdu_use, id_branch_taken,
             ex_memread, ex_rt, ex_mdu_start,
             dmem_req, dmem_ready, exc_req,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_clr, idex_clr, exmem_clr, memwb_clr,
             mdu_busy, state_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage MIPS pipeline, clocked on the falling edge.
// Optional HAZ_PERF_EN adds a saturating stall_cycles counter output.
module pipe_hazard_ctrl #(
   parameter int REGW       = 5,
   parameter int MDU_CYCLES = 32,
   parameter int CNTW       = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   pipe_hazard_ctrl_if.slave    bus
`ifdef HAZ_PERF_EN
   ,
   output logic [31:0]          stall_cycles
`endif
);
   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [CNTW-1:0] mdu_cnt_q, mdu_cnt_d;
   logic            mdu_busy_q, mdu_busy_d;

   logic mem_wait;
   logic load_use;
   logic mdu_use;
   logic pc_en_w, ifid_en_w, idex_en_w, exmem_en_w, memwb_en_w;
   logic ifid_clr_w, idex_clr_w, exmem_clr_w, memwb_clr_w;

   assign mem_wait = bus.dmem_req & ~bus.dmem_ready;
   assign load_use = bus.ex_memread && (bus.ex_rt != '0) &&
                     ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
   assign mdu_use  = mdu_busy_q & bus.id_mdu_use;

   always_comb begin
      pc_en_w     = 1'b1;
      ifid_en_w   = 1'b1;
      idex_en_w   = 1'b1;
      exmem_en_w  = 1'b1;
      memwb_en_w  = 1'b1;
      ifid_clr_w  = 1'b0;
      idex_clr_w  = 1'b0;
      exmem_clr_w = 1'b0;
      memwb_clr_w = 1'b0;
      if (rst) begin
         pc_en_w    = 1'b0;
         ifid_en_w  = 1'b0;
         idex_en_w  = 1'b0;
         exmem_en_w = 1'b0;
         memwb_en_w = 1'b0;
      end else if (bus.exc_req) begin
         ifid_clr_w  = 1'b1;
         idex_clr_w  = 1'b1;
         exmem_clr_w = 1'b1;
      end else if (mem_wait) begin
         pc_en_w     = 1'b0;
         ifid_en_w   = 1'b0;
         idex_en_w   = 1'b0;
         exmem_en_w  = 1'b0;
         memwb_clr_w = 1'b1;
      end else if (mdu_use || load_use) begin
         // Hold PC and IF/ID, inject a bubble into ID/EX; older stages drain.
         pc_en_w    = 1'b0;
         ifid_en_w  = 1'b0;
         idex_clr_w = 1'b1;
      end else if (bus.id_branch_taken) begin
         ifid_clr_w = 1'b1;
      end
   end

   always_comb begin
      state_d    = mem_wait ? MEM_WAIT : RUN;
      mdu_cnt_d  = mdu_cnt_q;
      mdu_busy_d = mdu_busy_q;
      if (bus.exc_req) begin
         state_d    = RUN;
         mdu_cnt_d  = '0;
         mdu_busy_d = 1'b0;
      end else if (mdu_busy_q) begin
         // A start while busy is ignored; the countdown keeps running even in MEM_WAIT.
         if (mdu_cnt_q == '0) begin
            mdu_busy_d = 1'b0;
         end else begin
            mdu_cnt_d = mdu_cnt_q - CNTW'(1);
         end
      end else if (bus.ex_mdu_start) begin
         mdu_cnt_d  = CNTW'(MDU_CYCLES - 1);
         mdu_busy_d = 1'b1;
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         mdu_cnt_q  <= '0;
         mdu_busy_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mdu_cnt_q  <= mdu_cnt_d;
         mdu_busy_q <= mdu_busy_d;
      end
   end

`ifdef HAZ_PERF_EN
   logic [31:0] stall_cnt_q;

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (!pc_en_w && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;
`endif

   assign bus.pc_en     = pc_en_w;
   assign bus.ifid_en   = ifid_en_w;
   assign bus.idex_en   = idex_en_w;
   assign bus.exmem_en  = exmem_en_w;
   assign bus.memwb_en  = memwb_en_w;
   assign bus.ifid_clr  = ifid_clr_w;
   assign bus.idex_clr  = idex_clr_w;
   assign bus.exmem_clr = exmem_clr_w;
   assign bus.memwb_clr = memwb_clr_w;
   assign bus.mdu_busy  = mdu_busy_q;
   assign bus.state_o   = state_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a cycle-level reference model.
// Define HAZ_PERF_EN to also check the stall_cycles counter.
module tb_pipe_hazard_ctrl;
   localparam int REGW = 5;
   localparam int MDU  = 4;
   localparam int CNTW = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.REGW(REGW)) hif ();
`ifdef HAZ_PERF_EN
   logic [31:0] stall_cycles;
`endif

   pipe_hazard_ctrl #(.REGW(REGW), .MDU_CYCLES(MDU), .CNTW(CNTW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (hif)
`ifdef HAZ_PERF_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   int vec_cnt = 0;
   int err_cnt = 0;

   // Reference model: edges of MDU occupancy left, memory-wait flag, stall count.
   int          m_left = 0;
   bit          m_wait = 1'b0;
   longint      m_perf = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Packed as {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem,memwb clears}.
   function automatic logic [8:0] model_ctl();
      logic [4:0] en;
      logic [3:0] clr;
      bit hazard_reg;
      if (rst) return 9'b0;
      en  = 5'b11111;
      clr = 4'b0000;
      hazard_reg = hif.ex_memread && hif.ex_rt != 0 &&
                   (hif.ex_rt == hif.id_rs || hif.ex_rt == hif.id_rt);
      if (hif.exc_req)                                   clr = 4'b1110;
      else if (hif.dmem_req && !hif.dmem_ready)          begin en = 5'b00001; clr = 4'b0001; end
      else if ((m_left > 0 && hif.id_mdu_use) || hazard_reg) begin en = 5'b00111; clr = 4'b0100; end
      else if (hif.id_branch_taken)                      clr = 4'b1000;
      return {en, clr};
   endfunction

   function automatic logic [8:0] dut_ctl();
      return {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
              hif.ifid_clr, hif.idex_clr, hif.exmem_clr, hif.memwb_clr};
   endfunction

   // Called right after a rising edge with inputs already applied; returns at the next rising edge.
   task automatic cycle(input string tag);
      logic [8:0] exp;
      #2;
      exp = model_ctl();
      chk({tag, ".ctl"}, 32'(dut_ctl()), 32'(exp));
      chk({tag, ".state"}, 32'(hif.state_o), 32'(m_wait));
      chk({tag, ".busy"}, 32'(hif.mdu_busy), 32'(m_left > 0));
`ifdef HAZ_PERF_EN
      chk({tag, ".perf"}, stall_cycles, m_perf[31:0]);
`endif
      @(negedge clk);
      if (rst) begin
         m_left = 0; m_wait = 0; m_perf = 0;
      end else begin
         if (!exp[8] && m_perf < 64'hFFFF_FFFF) m_perf++;
         if (hif.exc_req) begin
            m_left = 0; m_wait = 0;
         end else begin
            m_wait = hif.dmem_req && !hif.dmem_ready;
            if (m_left > 0)             m_left--;
            else if (hif.ex_mdu_start)  m_left = MDU;
         end
      end
      @(posedge clk);
   endtask

   task automatic idle();
      hif.id_rs = 0; hif.id_rt = 0; hif.id_mdu_use = 0; hif.id_branch_taken = 0;
      hif.ex_memread = 0; hif.ex_rt = 0; hif.ex_mdu_start = 0;
      hif.dmem_req = 0; hif.dmem_ready = 0; hif.exc_req = 0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      @(posedge clk);
      cycle("rst");
      cycle("rst");
      rst = 1'b0;
      cycle("idle");
      cycle("idle");

      // Load-use on r8, then the load moves on; then the r0 case.
      hif.ex_memread = 1; hif.ex_rt = 8; hif.id_rs = 8;
      cycle("lu_r8");
      idle(); cycle("lu_after");
      hif.ex_memread = 1; hif.ex_rt = 0; hif.id_rs = 0;
      cycle("lu_r0");
      idle(); cycle("idle");

      // Three wait states then ready.
      hif.dmem_req = 1; hif.dmem_ready = 0;
      for (int i = 0; i < 3; i++) cycle("mwait");
      hif.dmem_ready = 1; cycle("mready");
      idle(); cycle("mdone");

      // MDU start, HI/LO read stalls until busy drops, then proceeds.
      hif.ex_mdu_start = 1; cycle("mdu_start");
      idle(); hif.id_mdu_use = 1;
      for (int i = 0; i < 10 && m_left > 0; i++) cycle("mdu_stall");
      chk("mdu_bound", 32'(m_left), 32'd0);
      cycle("mdu_go");
      idle(); cycle("idle");

      // Exception while in MEM_WAIT with the MDU busy.
      hif.ex_mdu_start = 1; cycle("exc_mdu");
      idle(); hif.dmem_req = 1; cycle("exc_wait");
      hif.exc_req = 1; cycle("exc");
      idle(); cycle("exc_after");

      // Branch coincident with load-use, then branch alone.
      hif.id_branch_taken = 1; hif.ex_memread = 1; hif.ex_rt = 5; hif.id_rt = 5;
      cycle("br_stall");
      hif.ex_memread = 0; hif.ex_rt = 0;
      cycle("br_squash");
      idle(); cycle("idle");

      for (int n = 0; n < 800; n++) begin
         hif.id_rs           = REGW'($urandom_range(0, 3));
         hif.id_rt           = REGW'($urandom_range(0, 3));
         hif.ex_rt           = REGW'($urandom_range(0, 3));
         hif.ex_memread      = ($urandom_range(0, 2) == 0);
         hif.id_mdu_use      = ($urandom_range(0, 2) == 0);
         hif.id_branch_taken = ($urandom_range(0, 3) == 0);
         hif.ex_mdu_start    = ($urandom_range(0, 5) == 0);
         hif.dmem_req        = ($urandom_range(0, 2) == 0);
         hif.dmem_ready      = ($urandom_range(0, 1) == 0);
         hif.exc_req         = ($urandom_range(0, 19) == 0);
         cycle("rand");
      end

      idle();
      rst = 1'b1; cycle("rst2");
      rst = 1'b0; cycle("idle");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
